// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Lookup is combinational on the fetch PC; training comes from the branch
// resolved in ID, which also drives the mispredict flag and the statistics.
module branch_predictor #(
  parameter int unsigned IDX_BITS = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] if_pc,
  output logic        pred_taken,
  output logic [15:0] pred_next_pc,
  input  logic        upd_valid,
  input  logic [15:0] upd_pc,
  input  logic        upd_taken,
  input  logic [15:0] upd_target,
  input  logic [15:0] upd_pred_next_pc,
  output logic        upd_mispredict,
  output logic [15:0] stat_branches,
  output logic [15:0] stat_mispredicts
);

  localparam int unsigned Entries = 1 << IDX_BITS;
  localparam int unsigned TagW    = 16 - IDX_BITS;

  logic [Entries-1:0]           valid_q;
  logic [Entries-1:0][TagW-1:0] tag_q;
  logic [Entries-1:0][15:0]     target_q;
  logic [Entries-1:0][1:0]      ctr_q;

  logic [15:0] stat_branches_q, stat_branches_d;
  logic [15:0] stat_mispredicts_q, stat_mispredicts_d;

  logic [IDX_BITS-1:0] lk_idx, upd_idx;
  logic [TagW-1:0]     lk_tag, upd_tag;
  logic                lk_hit, upd_hit;
  logic [15:0]         actual_next_pc;

  logic        wr_en;
  logic [15:0] wr_target;
  logic [1:0]  wr_ctr;

  assign lk_idx  = if_pc[IDX_BITS-1:0];
  assign lk_tag  = if_pc[15:IDX_BITS];
  assign upd_idx = upd_pc[IDX_BITS-1:0];
  assign upd_tag = upd_pc[15:IDX_BITS];

  // Fetch-side lookup: reads the registered table only, so a same-cycle update is not bypassed.
  always_comb begin
    lk_hit       = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    pred_taken   = lk_hit && ctr_q[lk_idx][1];
    pred_next_pc = pred_taken ? target_q[lk_idx] : if_pc + 16'd1;
  end

  // Resolve the real next PC and compare with what fetch was told.
  always_comb begin
    actual_next_pc = upd_taken ? upd_target : upd_pc + 16'd1;
    upd_mispredict = upd_valid && (actual_next_pc != upd_pred_next_pc);
  end

  // Entry write decision: train on hit, allocate on taken miss, ignore not-taken miss.
  always_comb begin
    upd_hit   = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
    wr_en     = upd_valid && (upd_hit || upd_taken);
    wr_target = target_q[upd_idx];
    wr_ctr    = ctr_q[upd_idx];
    if (upd_hit) begin
      if (upd_taken) begin
        wr_target = upd_target;
        if (ctr_q[upd_idx] != 2'b11) wr_ctr = ctr_q[upd_idx] + 2'd1;
      end else if (ctr_q[upd_idx] != 2'b00) begin
        wr_ctr = ctr_q[upd_idx] - 2'd1;
      end
    end else begin
      wr_target = upd_target;
      wr_ctr    = 2'b10;
    end
  end

  // Saturating statistics counters.
  always_comb begin
    stat_branches_d    = stat_branches_q;
    stat_mispredicts_d = stat_mispredicts_q;
    if (upd_valid) begin
      if (stat_branches_q != 16'hFFFF) stat_branches_d = stat_branches_q + 16'd1;
      if (upd_mispredict && (stat_mispredicts_q != 16'hFFFF)) begin
        stat_mispredicts_d = stat_mispredicts_q + 16'd1;
      end
    end
  end

  // Table storage.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q  <= '0;
      tag_q    <= '0;
      target_q <= '0;
      ctr_q    <= {Entries{2'b01}};
    end else if (wr_en) begin
      valid_q[upd_idx]  <= 1'b1;
      tag_q[upd_idx]    <= upd_tag;
      target_q[upd_idx] <= wr_target;
      ctr_q[upd_idx]    <= wr_ctr;
    end
  end

  // Statistics registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_branches_q    <= '0;
      stat_mispredicts_q <= '0;
    end else begin
      stat_branches_q    <= stat_branches_d;
      stat_mispredicts_q <= stat_mispredicts_d;
    end
  end

  assign stat_branches    = stat_branches_q;
  assign stat_mispredicts = stat_mispredicts_q;

endmodule
